// File: rtl/serial_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_tx_if
// Brief    : Byte handshake bundle between the host byte source and serial_tx.
// Revision : 1.0 - initial release
// ============================================================================
interface serial_tx_if;
    logic [7:0] data_i;
    logic       valid_i;
    logic       ready_o;

    modport master (output data_i, output valid_i, input  ready_o);
    modport slave  (input  data_i, input  valid_i, output ready_o);
endinterface
`default_nettype wire

// File: rtl/serial_tx.sv
`default_nettype none
// ============================================================================
// Module   : serial_tx
// Brief    : UART frame transmitter with one-deep holding register; the
//            SERIAL_TX_PARITY_EN macro inserts an even parity bit after bit 7.
// Revision : 1.0 - initial release
// ============================================================================
module serial_tx #(
    parameter int STOP_BITS = 1
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        baud_rate_tick_i,
    serial_tx_if.slave  bus,
    output logic        tx_o,
    output logic        busy_o,
    output logic        done_o
);

    localparam logic [1:0] c_STOP_LAST = 2'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef SERIAL_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } t_state;

    t_state      r_state;
    t_state      w_state_nx;
    logic [7:0]  r_shift;
    logic [7:0]  w_shift_nx;
    logic [2:0]  r_bit_cnt;
    logic [2:0]  w_bit_cnt_nx;
    logic [1:0]  r_stop_cnt;
    logic [1:0]  w_stop_cnt_nx;
    logic [7:0]  r_hold;
    logic        r_hold_full;
    logic        r_tx;
    logic        r_busy;
    logic        r_done;
    logic        w_tx_nx;
    logic        w_done_nx;
    logic        w_load;
    logic        w_accept;
`ifdef SERIAL_TX_PARITY_EN
    logic        r_parity;
    logic        w_parity_nx;
`endif

    // Accept needs an empty holding register and load needs a full one,
    // so the two can never fire in the same cycle.
    assign w_accept    = bus.valid_i && !r_hold_full;
    assign bus.ready_o = !r_hold_full;
    assign tx_o        = r_tx;
    assign busy_o      = r_busy;
    assign done_o      = r_done;

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_shift     <= 8'h00;
            r_bit_cnt   <= 3'd0;
            r_stop_cnt  <= 2'd0;
            r_hold      <= 8'h00;
            r_hold_full <= 1'b0;
            r_tx        <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            r_parity    <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nx;
            r_shift    <= w_shift_nx;
            r_bit_cnt  <= w_bit_cnt_nx;
            r_stop_cnt <= w_stop_cnt_nx;
            r_tx       <= w_tx_nx;
            r_busy     <= (w_state_nx != S_IDLE);
            r_done     <= w_done_nx;
`ifdef SERIAL_TX_PARITY_EN
            r_parity   <= w_parity_nx;
`endif
            if (w_load) begin
                r_hold_full <= 1'b0;
            end else if (w_accept) begin
                r_hold      <= bus.data_i;
                r_hold_full <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_shift_nx    = r_shift;
        w_bit_cnt_nx  = r_bit_cnt;
        w_stop_cnt_nx = r_stop_cnt;
        w_done_nx     = 1'b0;
        w_load        = 1'b0;

        if (baud_rate_tick_i) begin
            case (r_state)
                S_IDLE: begin
                    w_load = r_hold_full;
                end
                S_START: begin
                    w_state_nx   = S_DATA;
                    w_bit_cnt_nx = 3'd0;
                end
                S_DATA: begin
                    w_shift_nx = {1'b0, r_shift[7:1]};
                    if (r_bit_cnt == 3'd7) begin
                        w_bit_cnt_nx = 3'd0;
`ifdef SERIAL_TX_PARITY_EN
                        w_state_nx   = S_PARITY;
`else
                        w_state_nx   = S_STOP;
`endif
                    end else begin
                        w_bit_cnt_nx = r_bit_cnt + 3'd1;
                    end
                end
`ifdef SERIAL_TX_PARITY_EN
                S_PARITY: begin
                    w_state_nx = S_STOP;
                end
`endif
                S_STOP: begin
                    if (r_stop_cnt == c_STOP_LAST) begin
                        w_stop_cnt_nx = 2'd0;
                        w_done_nx     = 1'b1;
                        w_state_nx    = S_IDLE;
                        w_load        = r_hold_full;
                    end else begin
                        w_stop_cnt_nx = r_stop_cnt + 2'd1;
                    end
                end
                default: begin
                    w_state_nx = S_IDLE;
                end
            endcase
        end

        if (w_load) begin
            w_shift_nx = r_hold;
            w_state_nx = S_START;
        end
    end

`ifdef SERIAL_TX_PARITY_EN
    // Data bits are consumed by the shifter, so parity is captured at load.
    assign w_parity_nx = w_load ? ^r_hold : r_parity;
`endif

    always_comb begin
        w_tx_nx = 1'b1;
        case (w_state_nx)
            S_START:  w_tx_nx = 1'b0;
            S_DATA:   w_tx_nx = w_shift_nx[0];
`ifdef SERIAL_TX_PARITY_EN
            S_PARITY: w_tx_nx = w_parity_nx;
`endif
            default:  w_tx_nx = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_tx
// Brief    : Directed self-checking bench for serial_tx (1 and 2 stop bits).
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_tx;

    localparam int c_PERIOD = 8;

    logic       clk;
    logic       rst;
    logic       tick;
    logic       valid;
    logic [7:0] data;
    logic       sel;
    int         n_cmp;
    int         n_err;
    int         done_cnt;

    logic       w_tx1, w_busy1, w_done1;
    logic       w_tx2, w_busy2, w_done2;
    logic       w_tx, w_busy, w_done, w_ready;

    serial_tx_if u_if1 ();
    serial_tx_if u_if2 ();

    assign u_if1.data_i  = data;
    assign u_if2.data_i  = data;
    assign u_if1.valid_i = valid & ~sel;
    assign u_if2.valid_i = valid & sel;

    serial_tx #(.STOP_BITS(1)) u_dut1 (
        .sysclk           (clk),
        .reset            (rst),
        .baud_rate_tick_i (tick),
        .bus              (u_if1.slave),
        .tx_o             (w_tx1),
        .busy_o           (w_busy1),
        .done_o           (w_done1)
    );

    serial_tx #(.STOP_BITS(2)) u_dut2 (
        .sysclk           (clk),
        .reset            (rst),
        .baud_rate_tick_i (tick),
        .bus              (u_if2.slave),
        .tx_o             (w_tx2),
        .busy_o           (w_busy2),
        .done_o           (w_done2)
    );

    assign w_tx    = sel ? w_tx2    : w_tx1;
    assign w_busy  = sel ? w_busy2  : w_busy1;
    assign w_done  = sel ? w_done2  : w_done1;
    assign w_ready = sel ? u_if2.ready_o : u_if1.ready_o;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One bit period: tick for one cycle, then idle; samples #1 after edges.
    task automatic tick_period();
        tick = 1'b1;
        @(posedge clk);
        #1;
        tick = 1'b0;
        if (w_done) done_cnt++;
        repeat (c_PERIOD - 1) begin
            @(posedge clk);
            #1;
            if (w_done) done_cnt++;
        end
    endtask

    task automatic accept(input logic [7:0] nb);
        valid = 1'b1;
        data  = nb;
        @(posedge clk);
        #1;
        valid = 1'b0;
        chk("ready_low_after_accept", {7'd0, w_ready}, 8'd0);
    endtask

    task automatic frame_bits(input logic [7:0] b, input int stops, input bit skip_start,
                              input bit acc, input logic [7:0] nb);
        done_cnt = 0;
        if (!skip_start) begin
            tick_period();
            chk("start_bit", {7'd0, w_tx}, 8'd0);
            chk("busy_start", {7'd0, w_busy}, 8'd1);
        end
        for (int i = 0; i < 8; i++) begin
            tick_period();
            chk("data_bit", {7'd0, w_tx}, {7'd0, b[i]});
            chk("busy_data", {7'd0, w_busy}, 8'd1);
            if (acc && i == 0) accept(nb);
        end
`ifdef SERIAL_TX_PARITY_EN
        tick_period();
        chk("parity_bit", {7'd0, w_tx}, {7'd0, ^b});
`endif
        for (int s = 0; s < stops; s++) begin
            tick_period();
            chk("stop_bit", {7'd0, w_tx}, 8'd1);
            chk("busy_stop", {7'd0, w_busy}, 8'd1);
        end
    endtask

    task automatic frame_end(input bit nxt);
        tick_period();
        chk("done_pulse_count", 8'(done_cnt), 8'd1);
        chk("end_tx", {7'd0, w_tx}, nxt ? 8'd0 : 8'd1);
        chk("end_busy", {7'd0, w_busy}, nxt ? 8'd1 : 8'd0);
    endtask

    initial begin
        n_cmp = 0; n_err = 0; done_cnt = 0;
        rst = 1'b1; tick = 1'b0; valid = 1'b0; data = 8'h00; sel = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_tx", {7'd0, w_tx}, 8'd1);
        chk("reset_ready", {7'd0, w_ready}, 8'd1);
        chk("reset_busy", {7'd0, w_busy}, 8'd0);
        chk("reset_done", {7'd0, w_done}, 8'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single frames, one stop bit
        accept(8'hA5);
        tick_period();
        chk("a5_start", {7'd0, w_tx}, 8'd0);
        chk("ready_after_load", {7'd0, w_ready}, 8'd1);
        frame_bits(8'hA5, 1, 1'b1, 1'b0, 8'h00);
        frame_end(1'b0);
        accept(8'h01);
        frame_bits(8'h01, 1, 1'b0, 1'b0, 8'h00);
        frame_end(1'b0);

        // Back-to-back with two stop bits
        sel = 1'b1;
        @(posedge clk);
        #1;
        accept(8'h0F);
        frame_bits(8'h0F, 2, 1'b0, 1'b1, 8'hF0);
        frame_end(1'b1);
        frame_bits(8'hF0, 2, 1'b1, 1'b0, 8'h00);
        frame_end(1'b0);
        sel = 1'b0;
        @(posedge clk);
        #1;

        // valid held high across three bytes
        valid = 1'b1;
        data  = 8'h11;
        @(posedge clk);
        #1;
        data = 8'h22;
        tick_period();
        chk("hold3_start", {7'd0, w_tx}, 8'd0);
        chk("hold3_second_held", {7'd0, w_ready}, 8'd0);
        data = 8'h33;
        frame_bits(8'h11, 1, 1'b1, 1'b0, 8'h00);
        chk("hold3_third_waits", {7'd0, w_ready}, 8'd0);
        frame_end(1'b1);
        valid = 1'b0;
        chk("hold3_third_taken", {7'd0, w_ready}, 8'd0);
        frame_bits(8'h22, 1, 1'b1, 1'b0, 8'h00);
        frame_end(1'b1);
        frame_bits(8'h33, 1, 1'b1, 1'b0, 8'h00);
        frame_end(1'b0);
        chk("hold3_ready_end", {7'd0, w_ready}, 8'd1);

        // Accept in the same cycle as a tick
        valid = 1'b1;
        data  = 8'h96;
        tick  = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
        tick  = 1'b0;
        chk("coinc_tx_idle", {7'd0, w_tx}, 8'd1);
        chk("coinc_busy_low", {7'd0, w_busy}, 8'd0);
        repeat (3) @(posedge clk);
        #1;
        frame_bits(8'h96, 1, 1'b0, 1'b0, 8'h00);
        frame_end(1'b0);

        // Reset asserted during data bit 4
        accept(8'h55);
        tick_period();
        for (int i = 0; i < 5; i++) tick_period();
        chk("pre_reset_bit4", {7'd0, w_tx}, 8'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("midreset_tx", {7'd0, w_tx}, 8'd1);
        chk("midreset_ready", {7'd0, w_ready}, 8'd1);
        chk("midreset_busy", {7'd0, w_busy}, 8'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        accept(8'h3C);
        frame_bits(8'h3C, 1, 1'b0, 1'b0, 8'h00);
        frame_end(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
